// File: rtl/dispatch_stage.sv
// Single-entry dispatch stage: holds one renamed instruction, tracks PRN busy state and
// routes to the ALU (0) or LSU (1) issue queue. Define DISPATCH_ZERO_PRN_EN to hardwire PRN 0 as ready.
module dispatch_stage #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [INST_ID_BITS-1:0]                in_inst_id,
  input  logic [31:0]                            in_raw_instr,
  input  logic [63:0]                            in_pc,
  input  logic [MAX_OPERANDS-1:0]                in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_output,
  input  logic                                   peek_valid,
  input  logic [PRN_BITS-1:0]                    peek_prn,
  output logic [1:0]                             iq_inst_valid,
  input  logic [1:0]                             iq_queue_ready,
  output logic [INST_ID_BITS-1:0]                out_inst_id,
  output logic [31:0]                            out_raw_instr,
  output logic [63:0]                            out_pc,
  output logic [MAX_OPERANDS-1:0]                out_prn_input_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn_input,
  output logic [MAX_OPERANDS-1:0]                out_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn_output,
  output logic [MAX_OPERANDS-1:0]                out_prn_input_ready
);

  localparam int PRN_COUNT = 2**PRN_BITS;

`ifdef DISPATCH_ZERO_PRN_EN
  localparam bit ZERO_PRN = 1'b1;
`else
  localparam bit ZERO_PRN = 1'b0;
`endif

  logic                    held;
  logic                    target;
  logic [MAX_OPERANDS-1:0] held_ready;
  logic [PRN_COUNT-1:0]    busy;

  logic                    fire;
  logic                    accept;
  logic                    in_target;
  logic [MAX_OPERANDS-1:0] lookup_ready;
  logic [MAX_OPERANDS-1:0] snoop_hit;
  logic [PRN_COUNT-1:0]    busy_set;
  logic [PRN_COUNT-1:0]    busy_clr;

  // Load/store class: bit 27 set with bit 25 clear.
  assign in_target = in_raw_instr[27] & ~in_raw_instr[25];

  assign fire     = held && iq_queue_ready[target] && !flush;
  assign in_ready = rst_n && !flush && (!held || fire);
  assign accept   = in_valid && in_ready;

  always_comb begin
    iq_inst_valid = 2'b00;
    if (rst_n && held && !flush) iq_inst_valid[target] = 1'b1;
  end

  // Lookup sees the busy table as it stood before this edge, plus the live broadcast.
  always_comb begin
    lookup_ready = '0;
    snoop_hit    = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      lookup_ready[j] = in_prn_input_valid[j] &&
                        (!busy[in_prn_input[j]] ||
                         (peek_valid && peek_prn == in_prn_input[j]) ||
                         (ZERO_PRN && in_prn_input[j] == '0));
      snoop_hit[j]    = out_prn_input_valid[j] && peek_valid && peek_prn == out_prn_input[j];
    end
  end

  assign out_prn_input_ready = held_ready | snoop_hit;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (peek_valid) busy_clr[peek_prn] = 1'b1;
    if (accept) begin
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        if (in_prn_output_valid[j] && !(ZERO_PRN && in_prn_output[j] == '0))
          busy_set[in_prn_output[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held                 <= 1'b0;
      target               <= 1'b0;
      held_ready           <= '0;
      busy                 <= '0;
      out_inst_id          <= '0;
      out_raw_instr        <= '0;
      out_pc               <= '0;
      out_prn_input_valid  <= '0;
      out_prn_input        <= '0;
      out_prn_output_valid <= '0;
      out_prn_output       <= '0;
    end else begin
      // Set wins over a same-cycle clear of the same PRN.
      busy <= (busy & ~busy_clr) | busy_set;
      if (accept) begin
        held                 <= 1'b1;
        target               <= in_target;
        held_ready           <= lookup_ready;
        out_inst_id          <= in_inst_id;
        out_raw_instr        <= in_raw_instr;
        out_pc               <= in_pc;
        out_prn_input_valid  <= in_prn_input_valid;
        out_prn_input        <= in_prn_input;
        out_prn_output_valid <= in_prn_output_valid;
        out_prn_output       <= in_prn_output;
      end else begin
        if (fire || flush) held <= 1'b0;
        if (held) held_ready <= held_ready | snoop_hit;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage; busy-table effects are observed
// through the readiness of later consumer instructions.
module tb_dispatch_stage;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_inst_id;
  logic [31:0]      in_raw_instr;
  logic [63:0]      in_pc;
  logic [2:0]       in_prn_input_valid;
  logic [2:0][5:0]  in_prn_input;
  logic [2:0]       in_prn_output_valid;
  logic [2:0][5:0]  in_prn_output;
  logic             peek_valid;
  logic [5:0]       peek_prn;
  logic [1:0]       iq_inst_valid;
  logic [1:0]       iq_queue_ready;
  logic [5:0]       out_inst_id;
  logic [31:0]      out_raw_instr;
  logic [63:0]      out_pc;
  logic [2:0]       out_prn_input_valid;
  logic [2:0][5:0]  out_prn_input;
  logic [2:0]       out_prn_output_valid;
  logic [2:0][5:0]  out_prn_output;
  logic [2:0]       out_prn_input_ready;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dispatch_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_inst_id           (in_inst_id),
    .in_raw_instr         (in_raw_instr),
    .in_pc                (in_pc),
    .in_prn_input_valid   (in_prn_input_valid),
    .in_prn_input         (in_prn_input),
    .in_prn_output_valid  (in_prn_output_valid),
    .in_prn_output        (in_prn_output),
    .peek_valid           (peek_valid),
    .peek_prn             (peek_prn),
    .iq_inst_valid        (iq_inst_valid),
    .iq_queue_ready       (iq_queue_ready),
    .out_inst_id          (out_inst_id),
    .out_raw_instr        (out_raw_instr),
    .out_pc               (out_pc),
    .out_prn_input_valid  (out_prn_input_valid),
    .out_prn_input        (out_prn_input),
    .out_prn_output_valid (out_prn_output_valid),
    .out_prn_output       (out_prn_output),
    .out_prn_input_ready  (out_prn_input_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic [5:0] id, input logic [31:0] raw, input logic [63:0] pc,
                            input logic [2:0] sv, input logic [5:0] s0, input logic [5:0] s1,
                            input logic [5:0] s2, input logic [2:0] dv, input logic [5:0] d0);
    in_valid            = 1'b1;
    in_inst_id          = id;
    in_raw_instr        = raw;
    in_pc               = pc;
    in_prn_input_valid  = sv;
    in_prn_input        = {s2, s1, s0};
    in_prn_output_valid = dv;
    in_prn_output       = {6'd0, 6'd0, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; peek_valid = 1'b0; peek_prn = '0;
    iq_queue_ready = 2'b11;
    drive_inst(6'd63, 32'h8B020020, 64'h0, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd1);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    step(); step();
    tests++;
    if (iq_inst_valid !== 2'b00) begin failed++; $display("FAIL rst_iq_valid got %b exp 00", iq_inst_valid); end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || iq_inst_valid !== 2'b00 || out_inst_id !== 6'd0 || out_prn_input_ready !== 3'b000) begin
      failed++;
      $display("FAIL post_rst got rdy=%b iq=%b id=%0d prdy=%b exp 1 00 0 000",
               in_ready, iq_inst_valid, out_inst_id, out_prn_input_ready);
    end
  endtask

  // ALU accept followed directly by a consumer of its destination PRN 9.
  task automatic test_back_to_back();
    drive_inst(6'd1, 32'h8B020020, 64'h1000, 3'b011, 6'd5, 6'd7, 6'd0, 3'b001, 6'd9);
    step();
    drive_inst(6'd2, 32'h8B020020, 64'h1004, 3'b001, 6'd9, 6'd0, 6'd0, 3'b001, 6'd10);
    #1;
    tests++;
    if (iq_inst_valid !== 2'b01 || out_prn_input_ready !== 3'b011) begin
      failed++;
      $display("FAIL alu_first got iq=%b prdy=%b exp 01 011", iq_inst_valid, out_prn_input_ready);
    end
    tests++;
    if (out_inst_id !== 6'd1 || out_pc !== 64'h1000 || out_raw_instr !== 32'h8B020020 || out_prn_output_valid !== 3'b001) begin
      failed++;
      $display("FAIL alu_fields got id=%0d pc=%h raw=%h dv=%b exp 1 1000 8b020020 001",
               out_inst_id, out_pc, out_raw_instr, out_prn_output_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; iq_queue_ready = 2'b00;
    #1;
    tests++;
    if (out_inst_id !== 6'd2 || iq_inst_valid !== 2'b01 || out_prn_input_ready !== 3'b000) begin
      failed++;
      $display("FAIL b2b_busy9 got id=%0d iq=%b prdy=%b exp 2 01 000", out_inst_id, iq_inst_valid, out_prn_input_ready);
    end
    peek_valid = 1'b1; peek_prn = 6'd9;
    #1;
    tests++;
    if (out_prn_input_ready !== 3'b001) begin failed++; $display("FAIL peek_bypass got %b exp 001", out_prn_input_ready); end
    step();
    peek_valid = 1'b0;
    #1;
    tests++;
    if (out_prn_input_ready !== 3'b001 || iq_inst_valid !== 2'b01 || out_inst_id !== 6'd2) begin
      failed++;
      $display("FAIL peek_sticky got prdy=%b iq=%b id=%0d exp 001 01 2", out_prn_input_ready, iq_inst_valid, out_inst_id);
    end
    iq_queue_ready = 2'b11;
    step();
    tests++;
    if (iq_inst_valid !== 2'b00 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL b2b_drain got iq=%b rdy=%b exp 00 1", iq_inst_valid, in_ready);
    end
  endtask

  task automatic test_lsu_stall();
    iq_queue_ready = 2'b01;
    drive_inst(6'd3, 32'hF9400020, 64'h2000, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd20);
    step();
    drive_inst(6'd4, 32'h8B020020, 64'h2004, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd21);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (iq_inst_valid !== 2'b10 || in_ready !== 1'b0 || out_inst_id !== 6'd3 || out_pc !== 64'h2000) begin
        failed++;
        $display("FAIL lsu_stall[%0d] got iq=%b rdy=%b id=%0d pc=%h exp 10 0 3 2000",
                 i, iq_inst_valid, in_ready, out_inst_id, out_pc);
      end
      step();
    end
    iq_queue_ready = 2'b11;
    #1;
    tests++;
    if (in_ready !== 1'b1 || iq_inst_valid !== 2'b10) begin
      failed++;
      $display("FAIL lsu_fire got rdy=%b iq=%b exp 1 10", in_ready, iq_inst_valid);
    end
    step();
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_inst_id !== 6'd4 || iq_inst_valid !== 2'b01) begin
      failed++;
      $display("FAIL lsu_next got id=%0d iq=%b exp 4 01", out_inst_id, iq_inst_valid);
    end
    step();
  endtask

  task automatic test_set_over_clear();
    drive_inst(6'd5, 32'h8B020020, 64'h3000, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd12);
    peek_valid = 1'b1; peek_prn = 6'd12;
    step();
    peek_valid = 1'b0;
    drive_inst(6'd6, 32'h8B020020, 64'h3004, 3'b111, 6'd12, 6'd9, 6'd5, 3'b000, 6'd0);
    step();
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_inst_id !== 6'd6 || out_prn_input_ready !== 3'b110) begin
      failed++;
      $display("FAIL set_wins got id=%0d prdy=%b exp 6 110", out_inst_id, out_prn_input_ready);
    end
    step();
  endtask

  task automatic test_flush();
    iq_queue_ready = 2'b00;
    drive_inst(6'd7, 32'h8B020020, 64'h4000, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd30);
    step();
    drive_inst(6'd8, 32'h8B020020, 64'h4004, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd31);
    flush = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0 || iq_inst_valid !== 2'b00) begin
      failed++;
      $display("FAIL flush_comb got rdy=%b iq=%b exp 0 00", in_ready, iq_inst_valid);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (iq_inst_valid !== 2'b00 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL flush_drop got iq=%b rdy=%b exp 00 1", iq_inst_valid, in_ready);
    end
    drive_inst(6'd9, 32'h8B020020, 64'h4008, 3'b011, 6'd31, 6'd30, 6'd0, 3'b000, 6'd0);
    step();
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_inst_id !== 6'd9 || out_prn_input_ready !== 3'b001) begin
      failed++;
      $display("FAIL flush_busy got id=%0d prdy=%b exp 9 001", out_inst_id, out_prn_input_ready);
    end
    iq_queue_ready = 2'b11;
    step();
  endtask

  task automatic test_zero_prn();
    logic [2:0] exp_rdy;
`ifdef DISPATCH_ZERO_PRN_EN
    exp_rdy = 3'b001;
`else
    exp_rdy = 3'b000;
`endif
    drive_inst(6'd10, 32'h8B020020, 64'h5000, 3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 6'd0);
    step();
    drive_inst(6'd11, 32'h8B020020, 64'h5004, 3'b001, 6'd0, 6'd0, 6'd0, 3'b000, 6'd0);
    step();
    in_valid = 1'b0; iq_queue_ready = 2'b00;
    #1;
    tests++;
    if (out_inst_id !== 6'd11 || out_prn_input_ready !== exp_rdy) begin
      failed++;
      $display("FAIL zero_prn got id=%0d prdy=%b exp 11 %b", out_inst_id, out_prn_input_ready, exp_rdy);
    end
    peek_valid = 1'b1; peek_prn = 6'd0;
    step();
    peek_valid = 1'b0;
    #1;
    tests++;
    if (out_prn_input_ready !== 3'b001) begin failed++; $display("FAIL zero_peek got %b exp 001", out_prn_input_ready); end
    iq_queue_ready = 2'b11;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lsu_stall();
    test_set_over_clear();
    test_flush();
    test_zero_prn();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
